// File: rtl/savestate_ctrl_if.sv
// Core state port and savestate buffer port seen by savestate_ctrl.
// master = controller side, slave = core / buffer side.
interface savestate_ctrl_if #(
   parameter int unsigned ADDR_W = 10
) ();
   logic              core_pause_req;
   logic              core_paused;
   logic [ADDR_W-1:0] st_addr;
   logic              st_rd;
   logic [31:0]       st_rd_data;
   logic              st_rd_valid;
   logic              st_wr;
   logic [31:0]       st_wr_data;
   logic [ADDR_W-1:0] buf_addr;
   logic              buf_wr;
   logic [31:0]       buf_wr_data;
   logic              buf_rd;
   logic [31:0]       buf_rd_data;

   modport master (
      output core_pause_req, st_addr, st_rd, st_wr, st_wr_data,
             buf_addr, buf_wr, buf_wr_data, buf_rd,
      input  core_paused, st_rd_data, st_rd_valid, buf_rd_data
   );

   modport slave (
      input  core_pause_req, st_addr, st_rd, st_wr, st_wr_data,
             buf_addr, buf_wr, buf_wr_data, buf_rd,
      output core_paused, st_rd_data, st_rd_valid, buf_rd_data
   );
endinterface

// File: rtl/savestate_ctrl.sv
// Savestate save/load sequencer: pauses the core and copies WORDS words between state port and buffer.
// Optional running sum of transferred words is enabled by SAVESTATE_CHECKSUM_EN.
module savestate_ctrl #(
   parameter int unsigned WORDS   = 1024,
   parameter int unsigned ADDR_W  = 10,
   parameter int unsigned TIMEOUT = 65535
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             savestate_start,
   input  logic             savestate_load,
   output logic             start_ack,
   output logic             start_busy,
   output logic             start_ok,
   output logic             start_err,
   output logic             load_ack,
   output logic             load_busy,
   output logic             load_ok,
   output logic             load_err,
   output logic [31:0]      state_checksum,
   savestate_ctrl_if.master core_bus
);
   localparam int unsigned CW    = ADDR_W + 1;
   localparam int unsigned TMO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0]    LAST_WORD = CW'(WORDS - 1);
   localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT - 1);

   typedef enum logic [3:0] {
      S_IDLE, S_ACK, S_PAUSE, S_SAVE_RD, S_SAVE_WAIT,
      S_LOAD_RD, S_LOAD_WR, S_FINISH, S_ERROR
   } state_e;

   typedef enum logic {OP_SAVE, OP_LOAD} op_e;

   state_e           state_q, state_d;
   op_e              op_q, op_d;
   logic             ack_cnt_q, ack_cnt_d;
   logic [CW-1:0]    word_q, word_d;
   logic [TMO_W-1:0] tmo_q, tmo_d;
   logic             tmo_inc;
   logic             start_prev_q, load_prev_q;
   logic             start_edge, load_edge;
   logic             pause_q, pause_d;
   logic             st_rd, st_wr, buf_rd, buf_wr;
   logic             accept_save, accept_load, is_save;
   logic             start_ack_q, start_ack_d, start_busy_q, start_busy_d;
   logic             start_ok_q, start_ok_d, start_err_q, start_err_d;
   logic             load_ack_q, load_ack_d, load_busy_q, load_busy_d;
   logic             load_ok_q, load_ok_d, load_err_q, load_err_d;

   always_comb begin
      start_edge = savestate_start & ~start_prev_q;
      load_edge  = savestate_load & ~load_prev_q;
      state_d    = state_q;
      op_d       = op_q;
      ack_cnt_d  = ack_cnt_q;
      word_d     = word_q;
      tmo_inc    = 1'b0;
      st_rd      = 1'b0;
      st_wr      = 1'b0;
      buf_rd     = 1'b0;
      buf_wr     = 1'b0;
      case (state_q)
         S_IDLE: begin
            ack_cnt_d = 1'b0;
            if (start_edge) begin
               op_d    = OP_SAVE;
               state_d = S_ACK;
            end else if (load_edge) begin
               op_d    = OP_LOAD;
               state_d = S_ACK;
            end
         end
         S_ACK: begin
            if (ack_cnt_q) state_d = S_PAUSE;
            else           ack_cnt_d = 1'b1;
         end
         S_PAUSE: begin
            if (core_bus.core_paused) begin
               word_d  = '0;
               state_d = (op_q == OP_SAVE) ? S_SAVE_RD : S_LOAD_RD;
            end else if (tmo_q == TMO_LAST) begin
               state_d = S_ERROR;
            end else begin
               tmo_inc = 1'b1;
            end
         end
         S_SAVE_RD: begin
            st_rd   = 1'b1;
            state_d = S_SAVE_WAIT;
         end
         S_SAVE_WAIT: begin
            if (core_bus.st_rd_valid) begin
               buf_wr = 1'b1;
               if (word_q == LAST_WORD) begin
                  state_d = S_FINISH;
               end else begin
                  word_d  = word_q + 1'b1;
                  state_d = S_SAVE_RD;
               end
            end else if (tmo_q == TMO_LAST) begin
               state_d = S_ERROR;
            end else begin
               tmo_inc = 1'b1;
            end
         end
         S_LOAD_RD: begin
            buf_rd  = 1'b1;
            state_d = S_LOAD_WR;
         end
         S_LOAD_WR: begin
            st_wr = 1'b1;
            if (word_q == LAST_WORD) begin
               state_d = S_FINISH;
            end else begin
               word_d  = word_q + 1'b1;
               state_d = S_LOAD_RD;
            end
         end
         S_FINISH: state_d = S_IDLE;
         S_ERROR:  state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
      // Wait counter restarts on every state change, including SAVE_RD -> SAVE_WAIT re-entry
      if (state_d != state_q) tmo_d = '0;
      else if (tmo_inc)       tmo_d = tmo_q + 1'b1;
      else                    tmo_d = tmo_q;
      pause_d = state_d inside {S_PAUSE, S_SAVE_RD, S_SAVE_WAIT, S_LOAD_RD, S_LOAD_WR};
   end

   always_comb begin
      accept_save  = (state_q == S_IDLE) && start_edge;
      accept_load  = (state_q == S_IDLE) && load_edge && !start_edge;
      is_save      = (op_q == OP_SAVE);
      start_ack_d  = (state_q == S_ACK) && is_save;
      load_ack_d   = (state_q == S_ACK) && !is_save;
      start_busy_d = start_busy_q;
      load_busy_d  = load_busy_q;
      if (state_q == S_ACK) begin
         if (is_save) start_busy_d = 1'b1;
         else         load_busy_d  = 1'b1;
      end
      if (state_q inside {S_FINISH, S_ERROR}) begin
         if (is_save) start_busy_d = 1'b0;
         else         load_busy_d  = 1'b0;
      end
      start_ok_d  = accept_save ? 1'b0 : (start_ok_q  | ((state_q == S_FINISH) && is_save));
      start_err_d = accept_save ? 1'b0 : (start_err_q | ((state_q == S_ERROR)  && is_save));
      load_ok_d   = accept_load ? 1'b0 : (load_ok_q   | ((state_q == S_FINISH) && !is_save));
      load_err_d  = accept_load ? 1'b0 : (load_err_q  | ((state_q == S_ERROR)  && !is_save));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         op_q         <= OP_SAVE;
         ack_cnt_q    <= 1'b0;
         word_q       <= '0;
         tmo_q        <= '0;
         start_prev_q <= 1'b0;
         load_prev_q  <= 1'b0;
         pause_q      <= 1'b0;
         start_ack_q  <= 1'b0;
         start_busy_q <= 1'b0;
         start_ok_q   <= 1'b0;
         start_err_q  <= 1'b0;
         load_ack_q   <= 1'b0;
         load_busy_q  <= 1'b0;
         load_ok_q    <= 1'b0;
         load_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         op_q         <= op_d;
         ack_cnt_q    <= ack_cnt_d;
         word_q       <= word_d;
         tmo_q        <= tmo_d;
         start_prev_q <= savestate_start;
         load_prev_q  <= savestate_load;
         pause_q      <= pause_d;
         start_ack_q  <= start_ack_d;
         start_busy_q <= start_busy_d;
         start_ok_q   <= start_ok_d;
         start_err_q  <= start_err_d;
         load_ack_q   <= load_ack_d;
         load_busy_q  <= load_busy_d;
         load_ok_q    <= load_ok_d;
         load_err_q   <= load_err_d;
      end
   end

`ifdef SAVESTATE_CHECKSUM_EN
   logic [31:0] sum_q, sum_d;

   always_comb begin
      sum_d = sum_q;
      if ((state_q == S_IDLE) && (start_edge || load_edge)) sum_d = '0;
      else if (buf_wr)                                      sum_d = sum_q + core_bus.st_rd_data;
      else if (st_wr)                                       sum_d = sum_q + core_bus.buf_rd_data;
   end

   always_ff @(posedge clk) begin
      if (reset) sum_q <= '0;
      else       sum_q <= sum_d;
   end

   assign state_checksum = sum_q;
`else
   assign state_checksum = '0;
`endif

   assign start_ack  = start_ack_q;
   assign start_busy = start_busy_q;
   assign start_ok   = start_ok_q;
   assign start_err  = start_err_q;
   assign load_ack   = load_ack_q;
   assign load_busy  = load_busy_q;
   assign load_ok    = load_ok_q;
   assign load_err   = load_err_q;

   assign core_bus.core_pause_req = pause_q;
   assign core_bus.st_addr        = word_q[ADDR_W-1:0];
   assign core_bus.buf_addr       = word_q[ADDR_W-1:0];
   assign core_bus.st_rd          = st_rd;
   assign core_bus.st_wr          = st_wr;
   assign core_bus.buf_rd         = buf_rd;
   assign core_bus.buf_wr         = buf_wr;
   assign core_bus.st_wr_data     = st_wr  ? core_bus.buf_rd_data : '0;
   assign core_bus.buf_wr_data    = buf_wr ? core_bus.st_rd_data  : '0;
endmodule
